// File: rtl/dmi_target_pkg.sv
// Shared types and constants for the DMI target: field layout, opcodes, register map, FSM states.
package dmi_target_pkg;

  localparam int unsigned ADDR_W   = 7;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned OP_W     = 2;
  localparam int unsigned REQ_W    = ADDR_W + DATA_W + OP_W;
  localparam int unsigned RESP_W   = DATA_W + 2;
  localparam int unsigned OP_LSB   = 0;
  localparam int unsigned DATA_LSB = OP_W;
  localparam int unsigned ADDR_LSB = OP_W + DATA_W;

  typedef enum logic [1:0] {
    DMI_NOP   = 2'd0,
    DMI_READ  = 2'd1,
    DMI_WRITE = 2'd2,
    DMI_RSVD  = 2'd3
  } dmi_op_e;

  typedef enum logic [1:0] {
    DMI_RESP_OK   = 2'd0,
    DMI_RESP_FAIL = 2'd2
  } dmi_resp_e;

  localparam logic [ADDR_W-1:0] ADDR_DATA0     = 7'h04;
  localparam logic [ADDR_W-1:0] ADDR_DATA1     = 7'h05;
  localparam logic [ADDR_W-1:0] ADDR_DMCONTROL = 7'h10;
  localparam logic [ADDR_W-1:0] ADDR_DMSTATUS  = 7'h11;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  // version 2 in [3:0]; allhalted/anyhalted both follow the single hart
  function automatic logic [DATA_W-1:0] dmstatus_value(input logic unlock, input logic halted);
    return {22'b0, halted, halted, unlock, 3'b0, 4'h2};
  endfunction

endpackage

// File: rtl/dmi_target_regs.sv
// Debug-module register file and access decode. With DMI_TARGET_LOCK_EN defined,
// writes are refused while jtag_unlock_i is low.
module dmi_target_regs
  import dmi_target_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              access_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [OP_W-1:0]   op_i,
  input  logic              jtag_unlock_i,
  input  logic              halted_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic [1:0]        resp_o,
  output logic              dmactive_o,
  output logic              ndmreset_o,
  output logic              haltreq_o,
  output logic              resumereq_o
);

  logic [DATA_W-1:0] data0_q, data0_d, data1_q, data1_d;
  logic dmactive_q, dmactive_d, ndmreset_q, ndmreset_d;
  logic haltreq_q, haltreq_d, resumereq_q, resumereq_d;
  logic wr_blocked;
  logic unused_wdata;

  assign unused_wdata = ^wdata_i[29:2];

`ifdef DMI_TARGET_LOCK_EN
  assign wr_blocked = ~jtag_unlock_i;
`else
  assign wr_blocked = 1'b0;
`endif

  always_comb begin
    data0_d     = data0_q;
    data1_d     = data1_q;
    dmactive_d  = dmactive_q;
    ndmreset_d  = ndmreset_q;
    haltreq_d   = haltreq_q;
    resumereq_d = 1'b0;
    rdata_o     = '0;
    resp_o      = DMI_RESP_OK;
    case (op_i)
      DMI_NOP: ;
      DMI_READ: begin
        case (addr_i)
          ADDR_DATA0:     rdata_o = data0_q;
          ADDR_DATA1:     rdata_o = data1_q;
          ADDR_DMCONTROL: rdata_o = {haltreq_q, 29'b0, ndmreset_q, dmactive_q};
          ADDR_DMSTATUS:  rdata_o = dmstatus_value(jtag_unlock_i, halted_i);
          default:        resp_o  = DMI_RESP_FAIL;
        endcase
      end
      DMI_WRITE: begin
        if (wr_blocked) begin
          resp_o = DMI_RESP_FAIL;
        end else begin
          case (addr_i)
            ADDR_DATA0: if (dmactive_q) data0_d = wdata_i;
            ADDR_DATA1: if (dmactive_q) data1_d = wdata_i;
            ADDR_DMCONTROL: begin
              dmactive_d  = wdata_i[0];
              ndmreset_d  = wdata_i[1];
              haltreq_d   = wdata_i[31];
              resumereq_d = wdata_i[30] & access_i;
              // dropping dmactive resets the abstract data registers
              if (!wdata_i[0]) begin
                data0_d = '0;
                data1_d = '0;
              end
            end
            default: resp_o = DMI_RESP_FAIL;
          endcase
        end
      end
      default: resp_o = DMI_RESP_FAIL;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data0_q     <= '0;
      data1_q     <= '0;
      dmactive_q  <= 1'b0;
      ndmreset_q  <= 1'b0;
      haltreq_q   <= 1'b0;
      resumereq_q <= 1'b0;
    end else begin
      resumereq_q <= resumereq_d;
      if (access_i) begin
        data0_q    <= data0_d;
        data1_q    <= data1_d;
        dmactive_q <= dmactive_d;
        ndmreset_q <= ndmreset_d;
        haltreq_q  <= haltreq_d;
      end
    end
  end

  assign dmactive_o  = dmactive_q;
  assign ndmreset_o  = ndmreset_q;
  assign haltreq_o   = haltreq_q;
  assign resumereq_o = resumereq_q;

endmodule

// File: rtl/dmi_target.sv
// DMI target: request/response handshake FSM with configurable access latency.
// Build option DMI_TARGET_LOCK_EN (see dmi_target_regs) gates writes on jtag_unlock_i.
module dmi_target
  import dmi_target_pkg::*;
#(
  parameter int unsigned AccessLatency = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [REQ_W-1:0]  dmi_req_i,
  input  logic              dmi_req_valid_i,
  output logic              dmi_req_ready_o,
  output logic [RESP_W-1:0] dmi_resp_o,
  output logic              dmi_resp_valid_o,
  input  logic              dmi_resp_ready_i,
  input  logic              jtag_unlock_i,
  input  logic              halted_i,
  output logic              dmactive_o,
  output logic              ndmreset_o,
  output logic              haltreq_o,
  output logic              resumereq_o
);

  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [REQ_W-1:0]  req_q, req_d;
  logic [RESP_W-1:0] resp_q, resp_d;
  logic              access;
  logic [DATA_W-1:0] reg_rdata;
  logic [1:0]        reg_resp;

  assign access = (state_q == ST_ACCESS) && (cnt_q == 4'd0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    resp_d  = resp_q;
    case (state_q)
      ST_IDLE: begin
        if (dmi_req_valid_i) begin
          req_d   = dmi_req_i;
          cnt_d   = 4'(AccessLatency);
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          resp_d  = {reg_rdata, reg_resp};
          state_d = ST_RESP;
        end
      end
      ST_RESP: if (dmi_resp_ready_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      resp_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      resp_q  <= resp_d;
    end
  end

  dmi_target_regs u_regs (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .access_i      (access),
    .addr_i        (req_q[ADDR_LSB +: ADDR_W]),
    .wdata_i       (req_q[DATA_LSB +: DATA_W]),
    .op_i          (req_q[OP_LSB +: OP_W]),
    .jtag_unlock_i (jtag_unlock_i),
    .halted_i      (halted_i),
    .rdata_o       (reg_rdata),
    .resp_o        (reg_resp),
    .dmactive_o    (dmactive_o),
    .ndmreset_o    (ndmreset_o),
    .haltreq_o     (haltreq_o),
    .resumereq_o   (resumereq_o)
  );

  assign dmi_req_ready_o  = (state_q == ST_IDLE);
  assign dmi_resp_valid_o = (state_q == ST_RESP);
  assign dmi_resp_o       = resp_q;

endmodule
